muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Iterative multiply/divide unit in the execute stage. It sits beside the ALU and is fed by the same register-file operand path (A = rs, B = rt).
- Implements MULT, MULTU, DIV and DIVU into HI/LO, plus MTHI and MTLO writes.
- hi/lo feed the writeback mux for MFHI and MFLO.
- busy drives the PC/pipeline stall so the CPU waits for results.

Parameters:
- WIDTH, 32, operand width. Only 32 is supported; other values are not verified.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous, active-high reset.
- start, input, 1, begin an operation. Sampled only while idle.
- mdu_op, input, 2, 00 MULT, 01 MULTU, 10 DIV, 11 DIVU. Sampled with start.
- A, input, WIDTH, multiplicand or dividend (rs).
- B, input, WIDTH, multiplier or divisor (rt).
- hi_we, input, 1, MTHI: HI <= A.
- lo_we, input, 1, MTLO: LO <= A.
- busy, output, 1, operation in progress.
- done, output, 1, one-cycle pulse when HI/LO are updated.
- hi, output, WIDTH, HI register.
- lo, output, WIDTH, LO register.

Behaviour:
- Clock and reset: single clock domain, clk. Reset is synchronous, active-high on rst; polarity and synchronicity are fixed.
- Reset:
  - Sets state IDLE, busy=0, done=0, hi=0, lo=0, and clears counter and working registers.
  - Reset asserted mid-operation aborts it; no done pulse is produced.
- States:
  - IDLE
  - CALC (32 iterations, counter 0..31)
  - FIX (sign correction and write)
- IDLE:
  - start=1 latches mdu_op, the sign flags of A and B, and |A| and |B|, then goes to CALC.
  - Magnitudes are taken only for signed ops.
  - |0x80000000| is 0x80000000, treated as unsigned.
- CALC:
  - Multiply: shift-add, one multiplier bit per cycle, into a 64-bit accumulator.
  - Divide: restoring, one quotient bit per cycle, with a 33-bit partial-remainder subtract.
  - After count 31, go to FIX.
- FIX:
  - Signed multiply: negate the 64-bit product when the operand signs differ. HI=product[63:32], LO=product[31:0].
  - Signed divide: quotient negated if the signs differ; remainder takes the dividend's sign. LO=quotient, HI=remainder.
  - Then: done=1 for one cycle, return to IDLE.
- Latency: start high in cycle 0 gives busy=1 in cycles 1..33, and done=1 plus new hi/lo visible in cycle 34.
  - busy is 0 in cycle 34.
  - A new start is accepted in cycle 34.
  - Latency is fixed for all operands, including divide-by-zero.
- Operands: A, B and mdu_op are captured only at start; later changes to them are ignored.
- Divide by zero (B=0): HI=dividend A (raw, unmodified), LO=0xFFFFFFFF, for both DIV and DIVU.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. No exception.
- start while busy: ignored.
- hi_we/lo_we while busy: ignored. The controller must stall MTHI/MTLO behind busy.
- start together with hi_we or lo_we in IDLE: start wins; the writes are dropped.
- hi_we and lo_we together in IDLE: both HI and LO are loaded with A.
- MTHI/MTLO are visible on hi/lo the next cycle; they do not pulse done.
- hi/lo hold their values between operations. They change only on a FIX cycle, an MTHI/MTLO write, or reset.

Decomposition:
- Add to the shared ctrl_encode_def.v defines:
  - MDU_MULT 2'b00, MDU_MULTU 2'b01, MDU_DIV 2'b10, MDU_DIVU 2'b11.
  - MDU_IDLE, MDU_CALC, MDU_FIX state encodings.
- The control unit decodes the funct field to mdu_op, start, hi_we and lo_we. The writeback mux gets MFHI/MFLO selects.
- One sub-module is natural: mdu_iter_core. It holds the 64-bit accumulator/remainder register and the one-bit-per-cycle shift-add/subtract step, controlled by a mul/div select and a step enable.
- muldiv_unit keeps the FSM, counter, sign handling and HI/LO registers.

Test Plan:
1. MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> cycle 34 done=1, HI=0xFFFFFFFE, LO=0x00000001; busy high exactly cycles 1..33.
2. MULT A=-7 (0xFFFFFFF9) B=3 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. DIV A=-7 B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
3. DIVU A=100 B=0 -> HI=100, LO=0xFFFFFFFF after 34 cycles. DIV A=0x80000000 B=0xFFFFFFFF -> LO=0x80000000, HI=0.
4. Ignored requests:
   - Start MULTU 5*6; in cycle 10 assert start with DIV and hi_we with A=0xDEADBEEF -> both ignored; HI=0, LO=30 at done.
   - Then in cycle 34, start DIVU 30/4 -> LO=7, HI=2.
5. rst in cycle 20 of a DIV -> next cycle busy=0, hi=lo=0, and no done pulse follows.
6. hi_we=1 A=0x12345678 -> HI=0x12345678. Then hi_we+lo_we A=0xA5A5A5A5 -> both 0xA5A5A5A5. start+lo_we in IDLE -> LO unchanged until done.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: shared op codes, FSM states and helpers for the multiply/divide unit
package muldiv_unit_pkg;
  localparam int XLEN = 32;
  typedef enum logic [1:0] {MDU_MULT = 2'b00, MDU_MULTU = 2'b01, MDU_DIV = 2'b10, MDU_DIVU = 2'b11} mdu_op_e;
  typedef enum logic [1:0] {MDU_IDLE, MDU_CALC, MDU_FIX} mdu_state_e;
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x, input logic sgn);
    return (sgn && x[XLEN-1]) ? -x : x;
  endfunction
endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: operand, control and HI/LO result bundle between the pipeline and the unit
interface muldiv_unit_if #(parameter int WIDTH = 32);
  logic start;
  logic [1:0] mdu_op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic hi_we;
  logic lo_we;
  logic busy;
  logic done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  modport master(output start, mdu_op, A, B, hi_we, lo_we, input busy, done, hi, lo);
  modport slave(input start, mdu_op, A, B, hi_we, lo_we, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_unit_iter_core.sv
// muldiv_unit_iter_core: 64-bit accumulator stepping one shift-add or restoring-divide bit per cycle
module muldiv_unit_iter_core #(parameter int WIDTH = 32) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic step,
  input  logic div,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [2*WIDTH-1:0] acc
);
  logic [WIDTH-1:0] m;
  logic [WIDTH:0] sum;
  logic [WIDTH+1:0] diff;
  // multiply adds the multiplicand into the upper half; divide trial-subtracts the shifted remainder
  always_comb begin
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, acc[0] ? m : {WIDTH{1'b0}}};
    diff = {1'b0, acc[2*WIDTH-1:WIDTH-1]} - {2'b0, m};
  end
  // low half starts as multiplier or dividend; a negative trial difference restores the remainder
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      m <= '0;
    end else if (load) begin
      acc <= {{WIDTH{1'b0}}, x};
      m <= y;
    end else if (step) begin
      acc <= !div ? {sum, acc[WIDTH-1:1]} :
             diff[WIDTH+1] ? {acc[2*WIDTH-2:0], 1'b0} : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
  end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU into HI/LO with MTHI/MTLO writes
module muldiv_unit import muldiv_unit_pkg::*; #(parameter int WIDTH = XLEN) (
  input logic clk,
  input logic rst,
  muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  mdu_state_e state, nxt;
  mdu_op_e op;
  logic [CW-1:0] cnt;
  logic sa, sb, bz, load, step, sgn_in, div_in, sgn_op, div_op, neg_q, neg_r;
  logic [WIDTH-1:0] ma, mb, fix_hi, fix_lo;
  logic [2*WIDTH-1:0] acc, prod;
  assign sgn_in = !bus.mdu_op[0];
  assign div_in = bus.mdu_op[1];
  assign ma = mag(bus.A, sgn_in);
  assign mb = mag(bus.B, sgn_in);
  assign sgn_op = op == MDU_MULT || op == MDU_DIV;
  assign div_op = op == MDU_DIV || op == MDU_DIVU;
  assign bus.busy = state != MDU_IDLE;
  muldiv_unit_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk(clk), .rst(rst), .load(load), .step(step), .div(div_op),
    .x(div_in ? ma : mb), .y(div_in ? mb : ma), .acc(acc)
  );
  // state register
  always_ff @(posedge clk) begin
    state <= rst ? MDU_IDLE : nxt;
  end
  // next state: idle until start, 32 iterations, one fix-up cycle
  always_comb begin
    nxt = state;
    load = 1'b0;
    step = 1'b0;
    load = state == MDU_IDLE && bus.start;
    step = state == MDU_CALC;
    nxt = state == MDU_IDLE ? (bus.start ? MDU_CALC : MDU_IDLE) :
          state == MDU_CALC ? (cnt == CW'(WIDTH-1) ? MDU_FIX : MDU_CALC) : MDU_IDLE;
  end
  // capture op and operand signs at start, count iterations
  always_ff @(posedge clk) begin
    if (rst) begin
      op <= MDU_MULT;
      {sa, sb, bz} <= '0;
      cnt <= '0;
    end else if (load) begin
      op <= mdu_op_e'(bus.mdu_op);
      sa <= sgn_in & bus.A[WIDTH-1];
      sb <= sgn_in & bus.B[WIDTH-1];
      bz <= bus.B == '0;
      cnt <= '0;
    end else if (step) begin
      cnt <= cnt + 1'b1;
    end
  end
  // sign correction; divide-by-zero forces an all-ones quotient and the remainder already equals A
  always_comb begin
    neg_q = sgn_op & (sa ^ sb);
    neg_r = sgn_op & sa;
    prod = neg_q ? -acc : acc;
    fix_hi = div_op ? (neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH]) : prod[2*WIDTH-1:WIDTH];
    fix_lo = div_op ? (bz ? {WIDTH{1'b1}} : neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]) : prod[WIDTH-1:0];
  end
  // HI/LO written on the fix cycle or by MTHI/MTLO in idle when no start is pending
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.hi <= '0;
      bus.lo <= '0;
      bus.done <= 1'b0;
    end else begin
      bus.done <= state == MDU_FIX;
      if (state == MDU_FIX) begin
        bus.hi <= fix_hi;
        bus.lo <= fix_lo;
      end else if (state == MDU_IDLE && !bus.start) begin
        if (bus.hi_we) bus.hi <= bus.A;
        if (bus.lo_we) bus.lo <= bus.A;
      end
    end
  end
endmodule
